// File: rtl/seq_comparison_unit_pkg.sv
// Shared compare opcodes, FSM states and the opcode-to-compare-bit decode.
package seq_comparison_unit_pkg;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_SGE = 3'b001;
   localparam logic [2:0] OP_SLT = 3'b010;
   localparam logic [2:0] OP_NE  = 3'b011;
   localparam logic [2:0] OP_EQ  = 3'b100;
   localparam logic [2:0] OP_UGE = 3'b101;
   localparam logic [2:0] OP_ULT = 3'b110;
   localparam logic [2:0] OP_UGT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Signed compares fall back to the operand sign bits when the signs differ,
   // which sidesteps overflow in the subtraction.
   function automatic logic cmp_bit(input logic [2:0] op, input logic a_msb,
                                    input logic b_msb, input logic d_msb,
                                    input logic carry, input logic zero);
      logic r;
      r = 1'b0;
      case (op)
         OP_SGE:  r = (a_msb != b_msb) ? ~a_msb : ~d_msb;
         OP_SLT:  r = (a_msb != b_msb) ?  a_msb :  d_msb;
         OP_NE:   r = ~zero;
         OP_EQ:   r =  zero;
         OP_UGE:  r =  carry;
         OP_ULT:  r = ~carry;
         OP_UGT:  r =  carry & ~zero;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_comparison_unit_digit_slice.sv
// One DIGIT-bit slice of A + ~B + cin, with carry out and slice-zero detect.
module cmp_digit_slice #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] diff,
   output logic             cout,
   output logic             zero
);

   logic [DIGIT:0] sum;

   assign sum  = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, cin};
   assign diff = sum[DIGIT-1:0];
   assign cout = sum[DIGIT];
   assign zero = (sum[DIGIT-1:0] == '0);

endmodule

// File: rtl/seq_comparison_unit.sv
// Multi-cycle A-B comparator: one DIGIT slice per cycle, LSB first, valid/ready on both sides.
module seq_comparison_unit
   import seq_comparison_unit_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int DIGIT        = 8,
   parameter int RESULT_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        a_in,
   input  logic [WIDTH-1:0]        b_in,
   input  logic [2:0]              opcode_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [RESULT_WIDTH-1:0] result_out,
   output logic                    carry_flag,
   output logic                    zero_flag,
   output logic                    neg_flag,
   output logic                    ovf_flag
);

   localparam int NUM_STEPS = WIDTH / DIGIT;
   localparam int SW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

   generate
      if (DIGIT < 1) begin : g_bad_digit
         $error("seq_comparison_unit: DIGIT must be >= 1");
      end else if (WIDTH % DIGIT != 0) begin : g_bad_width
         $error("seq_comparison_unit: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   state_e                  state_q;
   logic [WIDTH-1:0]        a_q, b_q;
   logic [2:0]              op_q;
   logic                    carry_q, zero_q;
   logic [SW-1:0]           step_q;
   logic [RESULT_WIDTH-1:0] result_q;
   logic                    carry_flag_q, zero_flag_q, neg_flag_q, ovf_flag_q;

   logic [DIGIT-1:0] s_diff;
   logic             s_cout, s_zero;
   logic             zero_d, cmp_d, ovf_d, a_msb, b_msb, d_msb, accept;

   // Operands shift right each step, so the active slice is always the low DIGIT bits.
   cmp_digit_slice #(.DIGIT(DIGIT)) u_slice (
      .a    (a_q[DIGIT-1:0]),
      .b    (b_q[DIGIT-1:0]),
      .cin  (carry_q),
      .diff (s_diff),
      .cout (s_cout),
      .zero (s_zero)
   );

   assign a_msb  = a_q[DIGIT-1];
   assign b_msb  = b_q[DIGIT-1];
   assign d_msb  = s_diff[DIGIT-1];
   assign zero_d = zero_q & s_zero;
   assign ovf_d  = (a_msb ^ b_msb) & (a_msb ^ d_msb);
   assign cmp_d  = cmp_bit(op_q, a_msb, b_msb, d_msb, s_cout, zero_d);

   assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= OP_NOP;
         carry_q      <= 1'b0;
         zero_q       <= 1'b0;
         step_q       <= '0;
         result_q     <= '0;
         carry_flag_q <= 1'b0;
         zero_flag_q  <= 1'b0;
         neg_flag_q   <= 1'b0;
         ovf_flag_q   <= 1'b0;
      end else if (state_q == S_RUN) begin
         a_q     <= a_q >> DIGIT;
         b_q     <= b_q >> DIGIT;
         carry_q <= s_cout;
         zero_q  <= zero_d;
         if (step_q == LAST_STEP) begin
            result_q     <= RESULT_WIDTH'(cmp_d);
            carry_flag_q <= s_cout;
            zero_flag_q  <= zero_d;
            neg_flag_q   <= d_msb;
            ovf_flag_q   <= ovf_d;
            state_q      <= S_DONE;
         end else begin
            step_q <= step_q + SW'(1);
         end
      end else if (accept) begin
         a_q     <= a_in;
         b_q     <= b_in;
         op_q    <= opcode_in;
         carry_q <= 1'b1;
         zero_q  <= 1'b1;
         step_q  <= '0;
         state_q <= S_RUN;
      end else if ((state_q == S_DONE) && out_ready) begin
         state_q <= S_IDLE;
      end
   end

   assign out_valid  = (state_q == S_DONE);
   assign result_out = result_q;
   assign carry_flag = carry_flag_q;
   assign zero_flag  = zero_flag_q;
   assign neg_flag   = neg_flag_q;
   assign ovf_flag   = ovf_flag_q;

endmodule

// File: tb/tb_seq_comparison_unit.sv
// Random and directed checks of seq_comparison_unit (DIGIT=8 and DIGIT=32) against an arithmetic model.
module tb_seq_comparison_unit;

   typedef struct packed {
      logic cmp, c, z, n, v;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, iv, ordy, dsel;
   logic [31:0] a, b;
   logic [2:0]  op;
   int          total = 0;
   int          bad   = 0;
   exp_t        last_m;

   logic        ir0, ov0, c0, z0, n0, v0;
   logic        ir1, ov1, c1, z1, n1, v1;
   logic [31:0] res0, res1;

   always #5 clk = ~clk;

   seq_comparison_unit #(.WIDTH(32), .DIGIT(8), .RESULT_WIDTH(32)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv & ~dsel), .in_ready(ir0),
      .a_in(a), .b_in(b), .opcode_in(op), .out_valid(ov0), .out_ready(ordy & ~dsel),
      .result_out(res0), .carry_flag(c0), .zero_flag(z0), .neg_flag(n0), .ovf_flag(v0)
   );

   seq_comparison_unit #(.WIDTH(32), .DIGIT(32), .RESULT_WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv & dsel), .in_ready(ir1),
      .a_in(a), .b_in(b), .opcode_in(op), .out_valid(ov1), .out_ready(ordy & dsel),
      .result_out(res1), .carry_flag(c1), .zero_flag(z1), .neg_flag(n1), .ovf_flag(v1)
   );

   wire        m_ir  = dsel ? ir1 : ir0;
   wire        m_ov  = dsel ? ov1 : ov0;
   wire [31:0] m_res = dsel ? res1 : res0;
   wire [3:0]  m_flg = dsel ? {c1, z1, n1, v1} : {c0, z0, n0, v0};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: flags and compare result from plain integer arithmetic.
   function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top);
      exp_t        m;
      longint      d;
      logic [31:0] u;
      d   = longint'($signed(ta)) - longint'($signed(tb));
      u   = ta - tb;
      m.c = (ta >= tb);
      m.z = (ta == tb);
      m.n = u[31];
      m.v = (d > 64'sd2147483647) || (d < -64'sd2147483648);
      case (top)
         3'b001:  m.cmp = ($signed(ta) >= $signed(tb));
         3'b010:  m.cmp = ($signed(ta) <  $signed(tb));
         3'b011:  m.cmp = (ta != tb);
         3'b100:  m.cmp = (ta == tb);
         3'b101:  m.cmp = (ta >= tb);
         3'b110:  m.cmp = (ta <  tb);
         3'b111:  m.cmp = (ta >  tb);
         default: m.cmp = 1'b0;
      endcase
      return m;
   endfunction

   // Issue one op (releasing any pending result in the same cycle), wait for it,
   // check latency and outputs; leaves the DUT holding the result in DONE.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top);
      int n, lat;
      last_m = model(ta, tb, top);
      a = ta; b = tb; op = top; iv = 1'b1; ordy = 1'b1;
      #1;
      n = 0;
      while (!m_ir && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("accept_rdy", {31'b0, m_ir}, 32'd1);
      @(posedge clk); #1;
      iv = 1'b0; ordy = 1'b0;
      a = $urandom; b = $urandom; op = 3'($urandom);
      lat = 0;
      if (!m_ov) begin
         lat = 1;
         @(posedge clk); #1;
         while (!m_ov && lat < 50) begin
            @(posedge clk); #1; lat++;
         end
      end
      chk("latency", lat, dsel ? 32'd1 : 32'd4);
      chk("result", m_res, {31'b0, last_m.cmp});
      chk("flags", {28'b0, m_flg}, {28'b0, last_m.c, last_m.z, last_m.n, last_m.v});
      chk("busy_rdy", {31'b0, m_ir}, 32'd0);
   endtask

   task automatic take();
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      rst_n = 1'b0; iv = 1'b0; ordy = 1'b0; dsel = 1'b0;
      a = '0; b = '0; op = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_ov", {31'b0, ov0}, 32'd0);
      chk("rst_res", res0, 32'd0);
      chk("rst_flags", {28'b0, c0, z0, n0, v0}, 32'd0);
      chk("rst_rdy", {31'b0, ir0}, 32'd1);

      run_op(32'hFFFFFFFF, 32'h1, 3'b010);
      chk("t1_slt", res0, 32'd1);
      run_op(32'hFFFFFFFF, 32'h1, 3'b110);
      chk("t1_ult", res0, 32'd0);
      chk("t1_carry", {31'b0, c0}, 32'd1);

      run_op(32'h80000000, 32'h80000000, 3'b100);
      chk("t2_eq", res0, 32'd1);
      chk("t2_flags", {28'b0, c0, z0, n0, v0}, 32'b1100);
      run_op(32'h80000000, 32'h80000000, 3'b011);
      chk("t2_ne", res0, 32'd0);

      run_op(32'h7FFFFFFF, 32'h80000000, 3'b001);
      chk("t3_sge", res0, 32'd1);
      chk("t3_ovf_neg", {30'b0, v0, n0}, 32'b11);
      run_op(32'h7FFFFFFF, 32'h80000000, 3'b111);
      chk("t3_ugt", res0, 32'd0);

      // Backpressure: result must hold while the consumer stalls.
      run_op(32'h12345678, 32'h9ABCDEF0, 3'b010);
      repeat (5) begin
         @(posedge clk); #1;
         chk("hold_ov", {31'b0, ov0}, 32'd1);
         chk("hold_rdy", {31'b0, ir0}, 32'd0);
         chk("hold_res", res0, {31'b0, last_m.cmp});
         chk("hold_flags", {28'b0, c0, z0, n0, v0}, {28'b0, last_m.c, last_m.z, last_m.n, last_m.v});
      end
      run_op(32'd10, 32'd3, 3'b111);

      // Reset mid-RUN at step 2 discards the op.
      take();
      a = 32'd1; b = 32'd2; op = 3'b110; iv = 1'b1;
      @(posedge clk); #1 iv = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      chk("t5_ov", {31'b0, ov0}, 32'd0);
      chk("t5_res", res0, 32'd0);
      chk("t5_flags", {28'b0, c0, z0, n0, v0}, 32'd0);
      chk("t5_rdy", {31'b0, ir0}, 32'd1);
      repeat (6) @(posedge clk);
      #1 chk("t5_no_ghost", {31'b0, ov0}, 32'd0);
      run_op(32'd5, 32'd5, 3'b100);
      chk("t5_eq", res0, 32'd1);

      run_op(32'd3, 32'd9, 3'b000);
      chk("t6_nop", res0, 32'd0);
      chk("t6_cn", {30'b0, c0, n0}, 32'b01);

      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         if ($urandom_range(0, 1) == 1) take();
         run_op(ra, rb, 3'($urandom));
      end
      take();

      dsel = 1'b1;
      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         if ($urandom_range(0, 1) == 1) take();
         run_op(ra, rb, 3'($urandom));
      end
      take();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
